vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter AW, default 20, is the SRAM word-address width.
REQ-002 Parameter DW, default 32, is the SRAM data width.
REQ-003 Parameter STARVE_LIMIT, default 8, is the maximum number of consecutive read grants while a write is pending.
REQ-004 clk  in  1  single system clock (50 MHz pixel domain); all logic SHALL be on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 rd_req  in  1  display fetch request, held until granted.
REQ-007 rd_addr  in  AW  display fetch word address.
REQ-008 rd_gnt  out  1  one-cycle pulse, read accepted.
REQ-009 rd_valid  out  1  one-cycle pulse, rd_data valid.
REQ-010 rd_data  out  DW  read data.
REQ-011 wr_req  in  1  host write request, held until granted.
REQ-012 wr_addr  in  AW  write word address.
REQ-013 wr_data  in  DW  write data.
REQ-014 wr_be  in  DW/8  byte enables, active-high.
REQ-015 wr_ack  out  1  one-cycle pulse, write completed.
REQ-016 ram_addr  out  AW  SRAM address.
REQ-017 ram_dout  out  DW  SRAM write data.
REQ-018 ram_din  in  DW  SRAM read data.
REQ-019 ram_doe  out  1  top-level tristate enable for ram_dout.
REQ-020 ram_be_n, ram_ce_n, ram_oe_n, ram_we_n  out  DW/8,1,1,1  SRAM strobes, active-low.

Function
REQ-021 The FSM SHALL have exactly these states: IDLE, RD0, RD1, WR0, WR1, WR2.
REQ-022 Arbitration SHALL occur in IDLE, RD1 and WR2 (arbitration points); the next access SHALL start in the following cycle with no idle gap.
REQ-023 If no request is present at an arbitration point, the FSM SHALL go to IDLE.
REQ-024 If only one request is present, it SHALL be granted; if both are present, read SHALL win unless starve_cnt == STARVE_LIMIT, in which case write SHALL win.
REQ-025 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each read grant while wr_req=1, and SHALL clear on a write grant or whenever wr_req=0.
REQ-026 The grant pulse (rd_gnt or wr_gnt-internal) SHALL occur in the arbitration cycle; address, data and byte enables SHALL be registered in that cycle, so a requester may change them in the next cycle.
REQ-027 In RD0 and RD1: ce_n=0, oe_n=0, we_n=1, be_n=0, doe=0.
REQ-028 ram_din SHALL be sampled at the end of RD1; rd_valid SHALL pulse in the cycle after RD1, giving rd_gnt-to-rd_valid latency of exactly 3 cycles.
REQ-029 In WR0–WR2: ce_n=0, oe_n=1, doe=1, be_n=~wr_be (registered). we_n SHALL be 0 only in WR1.
REQ-030 wr_ack SHALL pulse in WR2; a write SHALL take exactly 3 cycles.
REQ-031 In IDLE: ce_n=1, oe_n=1, we_n=1, doe=0, be_n all 1.
REQ-032 All SRAM outputs SHALL be registered, with no combinational path from request inputs to ram_* outputs.
REQ-033 A request deasserted before its grant SHALL be dropped without any SRAM access.

Reset
REQ-034 On rst_n=0, the block SHALL immediately (asynchronously) enter IDLE with ce_n=oe_n=we_n=1, be_n all 1, doe=0, rd_gnt=rd_valid=wr_ack=0, rd_data=0, ram_addr=0, ram_dout=0, and starve_cnt=0.
REQ-035 A reset during an access SHALL abort the access with no rd_valid or wr_ack, even a pending one.
REQ-036 The first grant is permitted in the first clock edge after rst_n rises.

Structure
REQ-037 Package vram_pkg SHALL hold the state encoding, the RD/WR cycle-count constants and the STARVE_LIMIT default.
REQ-038 No sub-module is required; the tristate buffer SHALL remain in the top level.

Verification
REQ-039 Single read: rd_addr=0x00010, SRAM model word=0xDEADBEEF, rd_req -> rd_gnt at t, rd_valid at t+3, rd_data=0xDEADBEEF, we_n never 0.
REQ-040 Single write: wr_addr=0x00020, wr_data=0x12345678, wr_be=4'b0011 -> we_n low for exactly 1 cycle, be_n=4'b1100, wr_ack 3 cycles after grant, and the model holds 0x????5678.
REQ-041 Contention: rd_req and wr_req held continuously -> 8 read grants, then 1 write grant, repeating; wr_ack recurs every 8*2+3=19 cycles.
REQ-042 Back-to-back: 4 reads to 0x0..0x3 -> rd_gnt every 2 cycles and 4 rd_valid pulses in address order with no IDLE cycle between.
REQ-043 Reset mid-write: rst_n low during WR1 -> we_n=1 and doe=0 in the same cycle, no wr_ack; after release, a new write completes normally.
REQ-044 Withdrawn request: wr_req pulsed for 1 cycle while a read is active (not at an arbitration point) -> no write occurs and starve_cnt=0.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM arbiter.
package vram_pkg;

  // One-hot-free binary encoding; arbitration happens in IDLE, RD1 and WR2.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4,
    WR2  = 3'd5
  } state_t;

  // Access lengths in clock cycles.
  localparam int RD_CYCLES        = 2;
  localparam int WR_CYCLES        = 3;
  // Default number of consecutive read grants tolerated while a write waits.
  localparam int STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/vram_arbiter.sv
// Two-port (display read / host write) arbiter in front of an async SRAM.
// Reads take 2 cycles, writes 3; reads win contention until the pending
// write has been passed over STARVE_LIMIT times. All SRAM strobes are
// registered; the tristate buffer on the data bus lives outside this block
// and is controlled by ram_doe.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW           = 20,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_gnt,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  input  logic            wr_req,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_be,
  output logic            wr_ack,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_dout,
  input  logic [DW-1:0]   ram_din,
  output logic            ram_doe,
  output logic [DW/8-1:0] ram_be_n,
  output logic            ram_ce_n,
  output logic            ram_oe_n,
  output logic            ram_we_n
);

  localparam int BW = DW / 8;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  // Total cycles from a read grant to rd_valid (access + sample register).
  localparam int RD_LAT = RD_CYCLES + 1;

  state_t          r_state;
  logic [SW-1:0]   r_starve_cnt;
  logic [AW-1:0]   r_ram_addr;
  logic [DW-1:0]   r_ram_dout;
  logic [BW-1:0]   r_be_n;
  logic            r_ce_n, r_oe_n, r_we_n, r_doe;
  logic            r_rd_valid, r_wr_ack;
  logic [DW-1:0]   r_rd_data;

  logic            w_arb, w_starved, w_wr_win, w_rd_gnt, w_wr_gnt;

  // Arbitration: grants are decided combinationally in the arbitration cycle.
  always_comb begin
    w_arb     = rst_n && (r_state == IDLE || r_state == RD1 || r_state == WR2);
    w_starved = (r_starve_cnt == SW'(STARVE_LIMIT));
    w_wr_win  = wr_req && (!rd_req || w_starved);
    w_wr_gnt  = w_arb && w_wr_win;
    w_rd_gnt  = w_arb && rd_req && !w_wr_win;
  end

  // Starvation counter: counts reads granted over a waiting write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_starve_cnt <= '0;
    else if (!wr_req || w_wr_gnt)
      r_starve_cnt <= '0;
    else if (w_rd_gnt && !w_starved)
      r_starve_cnt <= r_starve_cnt + 1'b1;
  end

  // Access FSM with registered SRAM strobes, read capture and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ram_addr <= '0;
      r_ram_dout <= '0;
      r_be_n     <= '1;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_doe      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_wr_ack   <= 1'b0;
    end else begin
      // Data is sampled at the end of RD1 and flagged the following cycle.
      r_rd_valid <= (r_state == RD1);
      r_wr_ack   <= (r_state == WR1);
      if (r_state == RD1)
        r_rd_data <= ram_din;

      if (w_rd_gnt) begin
        r_state    <= RD0;
        r_ram_addr <= rd_addr;
        r_be_n     <= '0;
        r_ce_n     <= 1'b0;
        r_oe_n     <= 1'b0;
        r_we_n     <= 1'b1;
        r_doe      <= 1'b0;
      end else if (w_wr_gnt) begin
        // Address, data and enables are captured here so the host may move on.
        r_state    <= WR0;
        r_ram_addr <= wr_addr;
        r_ram_dout <= wr_data;
        r_be_n     <= ~wr_be;
        r_ce_n     <= 1'b0;
        r_oe_n     <= 1'b1;
        r_we_n     <= 1'b1;
        r_doe      <= 1'b1;
      end else begin
        case (r_state)
          RD0: r_state <= RD1;
          WR0: begin
            r_state <= WR1;
            r_we_n  <= 1'b0;
          end
          WR1: begin
            r_state <= WR2;
            r_we_n  <= 1'b1;
          end
          default: begin
            // Arbitration point with nothing to do: park with the bus released.
            r_state <= IDLE;
            r_be_n  <= '1;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_doe   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rd_gnt   = w_rd_gnt;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign wr_ack   = r_wr_ack;
  assign ram_addr = r_ram_addr;
  assign ram_dout = r_ram_dout;
  assign ram_doe  = r_doe;
  assign ram_be_n = r_be_n;
  assign ram_ce_n = r_ce_n;
  assign ram_oe_n = r_oe_n;
  assign ram_we_n = r_we_n;

  // Keeps the access-length constants tied to the FSM they describe.
  logic w_unused_lat;
  assign w_unused_lat = (RD_LAT != 3) || (WR_CYCLES != 3);

endmodule
